// File: rtl/mux_seq_pkg.sv
//==== mux_seq_pkg : shared types/constants for the mux select sequencer, rev 1.0 ====
`default_nettype none

package mux_seq_pkg;

  localparam int NUM_IN = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [SEL_W-1:0] scan_start(input logic msb_first);
    return msb_first ? SEL_W'(NUM_IN - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] scan_end(input logic msb_first);
    return msb_first ? '0 : SEL_W'(NUM_IN - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_sel_sequencer_if.sv
//==== mux_sel_sequencer_if : load/scan bus of the mux select sequencer, rev 1.0 ====
`default_nettype none

interface mux_sel_sequencer_if;
  import mux_seq_pkg::*;

  logic              tick;
  logic              load_valid;
  logic [NUM_IN-1:0] load_data;
  logic              msb_first;
  logic              abort;
  logic              load_ready;
  logic [NUM_IN-1:0] word;
  logic [SEL_W-1:0]  sel;
  logic              e;
  logic              busy;
  logic              done;

  modport master (
    output tick, load_valid, load_data, msb_first, abort,
    input  load_ready, word, sel, e, busy, done
  );

  modport slave (
    input  tick, load_valid, load_data, msb_first, abort,
    output load_ready, word, sel, e, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/mux_seq_dwell_cnt.sv
//==== mux_seq_dwell_cnt : tick-qualified dwell counter with terminal flag, rev 1.0 ====
`default_nettype none

module mux_seq_dwell_cnt
  import mux_seq_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr,
  input  wire logic en,
  output logic      term
);

  localparam logic [CNT_W-1:0] c_TERM = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == c_TERM) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // clr dominates so a cancelled scan can never report a terminal tick
  assign term = en && !clr && (cnt_q == c_TERM);

endmodule

`default_nettype wire

// File: rtl/mux_sel_sequencer.sv
//==== mux_sel_sequencer : steps an 8:1 mux select across a loaded word, rev 1.0 ====
`default_nettype none

module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mux_sel_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_IN-1:0] word_q, word_d;
  logic              msb_q, msb_d;
  logic              e_q, e_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              cnt_clr;
  logic              cnt_en;
  logic              term;
  logic              at_end;

  assign accept  = bus.load_valid && (state_q == ST_IDLE);
  assign cnt_en  = (state_q == ST_RUN) && bus.tick;
  assign cnt_clr = (state_q != ST_RUN) || bus.abort;
  assign at_end  = (sel_q == scan_end(msb_q));

  mux_seq_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (term && at_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output flags are decoded from the next state so every output leaves a flop
  always_comb begin
    sel_d  = sel_q;
    word_d = word_q;
    msb_d  = msb_q;
    if (accept) begin
      word_d = bus.load_data;
      msb_d  = bus.msb_first;
      sel_d  = scan_start(bus.msb_first);
    end else if (state_q == ST_RUN) begin
      if (bus.abort) begin
        sel_d = '0;
      end else if (term && !at_end) begin
        sel_d = msb_q ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
      end
    end
    e_d     = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN) || (state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      word_q  <= '0;
      msb_q   <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      sel_q   <= sel_d;
      word_q  <= word_d;
      msb_q   <= msb_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.word       = word_q;
  assign bus.sel        = sel_q;
  assign bus.e          = e_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
//==== tb_mux_sel_sequencer : self-checking bench for mux_sel_sequencer, rev 1.0 ====
`default_nettype none

module tb_mux_sel_sequencer;

  typedef struct {
    logic [7:0] data;
    logic       msb;
    int         dwell;
    int         tick_per;
    logic [0:7] exp_bits;
    int         e_cycles;
  } scan_vec_t;

  typedef struct {
    logic [2:0] sel;
    logic       bit_v;
  } sb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [1:0] tick_s, lv_s, msb_s, ab_s;
  logic [7:0] ld_s [2];
  logic [1:0] rdy_w, e_w, busy_w, done_w;
  logic [7:0] word_w [2];
  logic [2:0] sel_w [2];

  sb_t       sbq[$];
  scan_vec_t vecs[6];

  mux_sel_sequencer_if if1 ();
  mux_sel_sequencer_if if3 ();

  mux_sel_sequencer #(.DWELL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mux_sel_sequencer #(.DWELL(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if1.tick       = tick_s[0];
  assign if1.load_valid = lv_s[0];
  assign if1.load_data  = ld_s[0];
  assign if1.msb_first  = msb_s[0];
  assign if1.abort      = ab_s[0];
  assign if3.tick       = tick_s[1];
  assign if3.load_valid = lv_s[1];
  assign if3.load_data  = ld_s[1];
  assign if3.msb_first  = msb_s[1];
  assign if3.abort      = ab_s[1];

  assign rdy_w[0]  = if1.load_ready;
  assign e_w[0]    = if1.e;
  assign busy_w[0] = if1.busy;
  assign done_w[0] = if1.done;
  assign word_w[0] = if1.word;
  assign sel_w[0]  = if1.sel;
  assign rdy_w[1]  = if3.load_ready;
  assign e_w[1]    = if3.e;
  assign busy_w[1] = if3.busy;
  assign done_w[1] = if3.done;
  assign word_w[1] = if3.word;
  assign sel_w[1]  = if3.sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input int d, input logic [7:0] exp_word);
    chk({tag, "_ready"}, rdy_w[d], 1);
    chk({tag, "_e"}, e_w[d], 0);
    chk({tag, "_sel"}, sel_w[d], 0);
    chk({tag, "_busy"}, busy_w[d], 0);
    chk({tag, "_done"}, done_w[d], 0);
    chk({tag, "_word"}, word_w[d], exp_word);
  endtask

  task automatic drive_quiet();
    tick_s = '0; lv_s = '0; msb_s = '0; ab_s = '0;
    ld_s[0] = 8'h00; ld_s[1] = 8'h00;
  endtask

  // Accept one load (tick high on the accept cycle) and follow the scan to IDLE
  task automatic run_scan(input scan_vec_t v, input bit hold_load);
    int d, hold, e_cnt, run_len, done_cnt, word_errs, done_e_errs;
    bit first, finished;
    logic [2:0] prev;
    sb_t s;
    d = (v.dwell == 3) ? 1 : 0;
    hold = v.dwell * v.tick_per;
    e_cnt = 0; run_len = 0; done_cnt = 0; word_errs = 0; done_e_errs = 0;
    first = 1'b1; finished = 1'b0; prev = '0;
    @(negedge clk);
    chk("ready_before_load", rdy_w[d], 1);
    lv_s[d] = 1'b1; ld_s[d] = v.data; msb_s[d] = v.msb; tick_s[d] = 1'b1; ab_s[d] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s.sel = v.msb ? 3'(7 - k) : 3'(k);
      s.bit_v = v.exp_bits[k];
      sbq.push_back(s);
    end
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (rdy_w[d] === 1'b1) begin
        finished = 1'b1;
        break;
      end
      if (e_w[d] === 1'b1) begin
        e_cnt++;
        if (first || sel_w[d] != prev) begin
          if (!first) chk("dwell_len", run_len, hold);
          if (sbq.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
          end else begin
            s = sbq.pop_front();
            chk("scan_sel", sel_w[d], s.sel);
            chk("mux_out", word_w[d][sel_w[d]], s.bit_v);
          end
          first = 1'b0;
          run_len = 1;
        end else begin
          run_len++;
        end
        prev = sel_w[d];
      end
      if (done_w[d] === 1'b1) begin
        done_cnt++;
        if (e_w[d] !== 1'b0) done_e_errs++;
      end
      if (word_w[d] !== v.data) word_errs++;
      lv_s[d] = hold_load; ld_s[d] = 8'hFF; msb_s[d] = ~v.msb;
      tick_s[d] = ((n % v.tick_per) == 0);
    end
    lv_s[d] = 1'b0; tick_s[d] = 1'b0;
    chk("scan_finished", finished, 1);
    chk("last_dwell_len", run_len, hold);
    chk("e_cycles", e_cnt, v.e_cycles);
    chk("done_pulses", done_cnt, 1);
    chk("e_low_in_done", done_e_errs, 0);
    chk("word_held", word_errs, 0);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("idle_after_scan_busy", busy_w[d], 0);
    chk("idle_after_scan_word", word_w[d], v.data);
    sbq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int dones;
    vecs[0] = '{8'hA5, 1'b0, 1, 1, 8'b10100101, 8};
    vecs[1] = '{8'h81, 1'b1, 3, 2, 8'b10000001, 48};
    vecs[2] = '{8'h36, 1'b0, 1, 2, 8'b01101100, 16};
    vecs[3] = '{8'hC5, 1'b1, 3, 1, 8'b11000101, 24};
    vecs[4] = '{8'h0F, 1'b0, 3, 3, 8'b11110000, 72};
    vecs[5] = '{8'hA5, 1'b1, 1, 1, 8'b10100101, 8};

    drive_quiet();
    repeat (3) @(negedge clk);
    chk_idle("reset1", 0, 8'h00);
    chk_idle("reset3", 1, 8'h00);
    rst_n = 1'b1;

    // tick and abort in IDLE must not start anything
    tick_s = 2'b11; ab_s = 2'b11;
    repeat (5) @(negedge clk);
    chk_idle("idle_ignore1", 0, 8'h00);
    chk_idle("idle_ignore3", 1, 8'h00);
    drive_quiet();

    foreach (vecs[i]) run_scan(vecs[i], 1'b0);

    // load_valid held with 0xFF through a scan of 0xA5
    run_scan(vecs[0], 1'b1);

    // abort when sel reaches 4
    @(negedge clk);
    lv_s[0] = 1'b1; ld_s[0] = 8'h5C; msb_s[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lv_s[0] = 1'b0; tick_s[0] = 1'b1;
      if (e_w[0] === 1'b1 && sel_w[0] == 3'd4) begin
        ab_s[0] = 1'b1;
        found = 1'b1;
        break;
      end
    end
    chk("abort_reached_sel4", found, 1);
    @(negedge clk);
    ab_s[0] = 1'b0;
    chk_idle("abort_mid", 0, 8'h5C);
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) dones++;
    end
    chk("abort_mid_no_done", dones, 0);
    chk("abort_mid_stays_idle", rdy_w[0], 1);
    tick_s[0] = 1'b0;

    // abort on the terminal tick at the end value
    @(negedge clk);
    lv_s[0] = 1'b1; ld_s[0] = 8'h3A; msb_s[0] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lv_s[0] = 1'b0; tick_s[0] = 1'b1;
      if (e_w[0] === 1'b1 && sel_w[0] == 3'd0) begin
        ab_s[0] = 1'b1;
        found = 1'b1;
        break;
      end
    end
    chk("abort_term_reached_end", found, 1);
    dones = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      ab_s[0] = 1'b0;
      if (done_w[0] === 1'b1) dones++;
      if (n == 0) chk_idle("abort_term", 0, 8'h3A);
    end
    chk("abort_term_no_done", dones, 0);
    tick_s[0] = 1'b0;

    // asynchronous reset at sel=3 mid-dwell on the DWELL=3 instance
    @(negedge clk);
    lv_s[1] = 1'b1; ld_s[1] = 8'h5C; msb_s[1] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      lv_s[1] = 1'b0; tick_s[1] = 1'b1;
      if (e_w[1] === 1'b1 && sel_w[1] == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("reset_reached_sel3", found, 1);
    @(negedge clk);
    chk("reset_mid_dwell_sel", sel_w[1], 3);
    #2 rst_n = 1'b0;
    #1 chk_idle("reset_async", 1, 8'h00);
    drive_quiet();
    @(negedge clk);
    rst_n = 1'b1;
    tick_s = 2'b11;
    repeat (4) @(negedge clk);
    chk_idle("after_release", 1, 8'h00);
    drive_quiet();
    run_scan(vecs[3], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
